// File: rtl/sd_cic_decimator_pkg.sv
// Purpose : shared sigma-delta constants and helpers for the CIC decimator.
// Latency : n/a (package: width functions, bit mapping, clamp/scale).
// Backpres: n/a.
//
// Contents:
//   acc_width()   - integrator/comb width: ORDER*DEC_RATE_LOG2 + 2
//   w_width()     - clamped result width:  ORDER*DEC_RATE_LOG2 + 1
//   SD_BIT_ONE / SD_BIT_ZERO - +1 / -1 values a sigma-delta bit maps to
//   clamp_scale() - saturate a comb result to W bits, then align to the output width
package sd_cic_decimator_pkg;

    // Wide enough for the largest legal accumulator (4*8+2 = 34 bits) plus
    // any left shift towards a wider output.
    localparam int SCALE_W = 64;

    localparam logic signed [1:0] SD_BIT_ONE  = 2'sb01;
    localparam logic signed [1:0] SD_BIT_ZERO = 2'sb11;

    function automatic int acc_width(input int order, input int dec_rate_log2);
        return order * dec_rate_log2 + 2;
    endfunction

    function automatic int w_width(input int order, input int dec_rate_log2);
        return order * dec_rate_log2 + 1;
    endfunction

    // The comb result spans [-2^(W-1), +2^(W-1)]; only the positive end can
    // overflow a W-bit signed value, but both ends are clamped for safety.
    // Narrowing uses an arithmetic shift, so it truncates toward -infinity.
    function automatic logic signed [SCALE_W-1:0] clamp_scale(
        input logic signed [SCALE_W-1:0] c,
        input int                        w,
        input int                        out_w
    );
        logic signed [SCALE_W-1:0] hi;
        logic signed [SCALE_W-1:0] lo;
        logic signed [SCALE_W-1:0] v;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (c > hi) begin
            v = hi;
        end else if (c < lo) begin
            v = lo;
        end else begin
            v = c;
        end
        if (out_w >= w) begin
            return v <<< (out_w - w);
        end
        return v >>> (w - out_w);
    endfunction

endpackage

// File: rtl/sd_cic_comb_stage.sv
// Purpose : one CIC comb (differentiator) stage, y = x - delay.
// Latency : y is combinational from x; the delay register updates on load.
// Backpres: none; load is the decimation strobe from the parent.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears the delay)
//   load      - decimation event: capture x into the delay register
//   x         - stage input (ACC bits, two's complement, wraps modulo 2^ACC)
//   y         - stage output x - delay (same width, wraps modulo 2^ACC)
module sd_cic_comb_stage #(
    parameter int ACC = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic signed [ACC-1:0] x,
    output logic signed [ACC-1:0] y
);

    logic signed [ACC-1:0] delay_q;
    logic signed [ACC-1:0] delay_d;

    always_comb begin
        delay_d = delay_q;
        if (load) begin
            delay_d = x;
        end
    end

    // Modulo arithmetic is intentional: integrator wrap cancels out here.
    assign y = x - delay_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q <= '0;
        end else begin
            delay_q <= delay_d;
        end
    end

endmodule

// File: rtl/sd_cic_decimator.sv
// Purpose : sinc^ORDER CIC decimator turning a 1-bit sigma-delta stream into signed PCM.
// Latency : out/outValid registered, valid the clock after the en cycle completing a window.
// Backpres: none; consumer must take out on the outValid pulse (held until the next one).
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset, clears all state
//   en        - sample strobe; in is consumed and state advances only when en=1
//   in        - sigma-delta bit, 1 -> +1, 0 -> -1
//   out       - signed decimated sample, OUT_WIDTH bits, holds between pulses
//   outValid  - one-cycle pulse marking a new out
module sd_cic_decimator
    import sd_cic_decimator_pkg::*;
#(
    parameter int ORDER         = 3,
    parameter int DEC_RATE_LOG2 = 4,
    parameter int OUT_WIDTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        in,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        outValid
);

    localparam int ACC    = acc_width(ORDER, DEC_RATE_LOG2);
    localparam int W      = w_width(ORDER, DEC_RATE_LOG2);
    localparam int WARM_W = $clog2(ORDER + 1);

    localparam logic [DEC_RATE_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [WARM_W-1:0]        WARM_DONE  = WARM_W'(ORDER);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [ACC-1:0]       integ_q [ORDER];
    logic signed [ACC-1:0]       integ_d [ORDER];
    logic [DEC_RATE_LOG2-1:0]    phase_q;
    logic [DEC_RATE_LOG2-1:0]    phase_d;
    logic [WARM_W-1:0]           warm_q;
    logic [WARM_W-1:0]           warm_d;
    logic signed [OUT_WIDTH-1:0] out_q;
    logic signed [OUT_WIDTH-1:0] out_d;
    logic                        valid_q;
    logic                        valid_d;

    logic                        dec_evt;
    logic signed [ACC-1:0]       in_step;
    logic signed [ACC-1:0]       comb_out;

    assign in_step = in ? ACC'(SD_BIT_ONE) : ACC'(SD_BIT_ZERO);
    assign dec_evt = en && (phase_q == PHASE_LAST);

    // ------------------------------------------------------------------
    // Integrators and phase counter
    // All stages update together from the previous cycle's values, so each
    // stage sees its predecessor one sample late. This adds ORDER-1 samples
    // of pure delay but keeps every adder a single level deep.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
        end
        phase_d = phase_q;
        if (en) begin
            integ_d[0] = integ_q[0] + in_step;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            phase_d = phase_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Comb chain, evaluated combinationally on the decimation event from
    // the post-update value of the last integrator.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        logic signed [ACC-1:0] x_in;
        logic signed [ACC-1:0] y_out;

        if (g == 0) begin : g_first
            assign x_in = integ_d[ORDER-1];
        end else begin : g_next
            assign x_in = g_comb[g-1].y_out;
        end

        sd_cic_comb_stage #(
            .ACC (ACC)
        ) u_comb (
            .clk  (clk),
            .rst  (rst),
            .load (dec_evt),
            .x    (x_in),
            .y    (y_out)
        );
    end

    assign comb_out = g_comb[ORDER-1].y_out;

    // ------------------------------------------------------------------
    // Warm-up and output register
    // The first ORDER events only prime the comb delays; their results
    // contain the reset state of the delays and are discarded.
    // ------------------------------------------------------------------
    always_comb begin
        warm_d  = warm_q;
        out_d   = out_q;
        valid_d = 1'b0;
        if (dec_evt) begin
            if (warm_q != WARM_DONE) begin
                warm_d = warm_q + 1'b1;
            end else begin
                out_d   = OUT_WIDTH'(clamp_scale(SCALE_W'(comb_out), W, OUT_WIDTH));
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            phase_q <= '0;
            warm_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
            phase_q <= phase_d;
            warm_q  <= warm_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out      = out_q;
    assign outValid = valid_q;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Purpose : self-checking bench for sd_cic_decimator at default parameters.
// Latency : expects outValid one clock after each window-completing en cycle.
// Backpres: n/a (DUT has none).
module tb_sd_cic_decimator;

    localparam int ORDER = 3;
    localparam int DLOG2 = 4;
    localparam int R     = 16;
    localparam int OUT_W = 16;
    localparam int W     = ORDER * DLOG2 + 1;
    localparam int HLEN  = ORDER * (R - 1) + 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    in;
    logic signed [OUT_W-1:0] out;
    logic                    outValid;

    sd_cic_decimator #(
        .ORDER         (ORDER),
        .DEC_RATE_LOG2 (DLOG2),
        .OUT_WIDTH     (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in       (in),
        .out      (out),
        .outValid (outValid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: direct FIR with the sinc^ORDER impulse response,
    // applied to the full sample history since reset.
    int     h [HLEN];
    int     xs[$];
    int     exp_q[$];
    int     n_en;
    int     n_evt;
    longint exp_hold;

    // Pulse statistics since the last reset.
    longint cyc;
    longint last_cyc;
    int     npulse;
    int     first_en;
    int     min_sp;
    int     max_sp;

    // Table-driven value check, active during table records only.
    bit     tbl_active;
    longint tbl_exp;

    typedef struct {
        logic [3:0]  pat;
        int          plen;
        int          en_div;
        int          n_en;
        longint      exp_out;
        int          exp_first;
        int          exp_spacing;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void build_h();
        int tmp[HLEN];
        int len;
        for (int i = 0; i < HLEN; i++) h[i] = (i < R) ? 1 : 0;
        len = R;
        for (int s = 1; s < ORDER; s++) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) tmp[i+j] += h[i];
            len += R - 1;
            for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
        end
    endfunction

    // The DUT integrators see each predecessor one sample late, which is a
    // pure (ORDER-1)-sample delay of the ideal filter.
    function automatic longint model_out();
        longint acc;
        int     n;
        int     idx;
        acc = 0;
        n   = xs.size();
        for (int j = 0; j < HLEN; j++) begin
            idx = n - 1 - (ORDER - 1) - j;
            if (idx >= 0) acc += longint'(h[j]) * longint'(xs[idx]);
        end
        if (acc > (2 ** (W - 1)) - 1) acc = (2 ** (W - 1)) - 1;
        if (acc < -(2 ** (W - 1)))    acc = -(2 ** (W - 1));
        return acc * (2 ** (OUT_W - W));
    endfunction

    function automatic void model_reset();
        xs.delete();
        exp_q.delete();
        n_en     = 0;
        n_evt    = 0;
        exp_hold = 0;
        npulse   = 0;
        first_en = -1;
        min_sp   = 1 << 30;
        max_sp   = -1;
    endfunction

    // Called just after a falling edge: drive, let one rising edge pass,
    // then compare at the next falling edge.
    task automatic step(input logic e, input logic b);
        bit pushed;
        pushed = 1'b0;
        en = e;
        in = b;
        if (e) begin
            xs.push_back(b ? 1 : -1);
            n_en++;
            if (n_en % R == 0) begin
                n_evt++;
                if (n_evt > ORDER) begin
                    exp_q.push_back(int'(model_out()));
                    pushed = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("valid_timing", longint'(outValid), longint'(pushed));
        if (outValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", longint'(npulse), -1);
            end else begin
                exp_hold = exp_q.pop_front();
            end
            if (npulse == 0) begin
                first_en = n_en;
            end else begin
                if (int'(cyc - last_cyc) < min_sp) min_sp = int'(cyc - last_cyc);
                if (int'(cyc - last_cyc) > max_sp) max_sp = int'(cyc - last_cyc);
            end
            last_cyc = cyc;
            npulse++;
            if (tbl_active) check("tbl_val", longint'(out), tbl_exp);
        end
        check("model_out", longint'(out), exp_hold);
    endtask

    // Assert reset on a falling edge; outputs must clear without a clock.
    task automatic do_reset(input bit chk);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        if (chk) begin
            check("rst_out_async", longint'(out), 0);
            check("rst_valid_async", longint'(outValid), 0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        in  = 1'b0;
        cyc = 0;
        last_cyc   = 0;
        tbl_active = 1'b0;
        tbl_exp    = 0;
        build_h();
        model_reset();

        vecs[0] = '{4'b0001, 1, 1, 160, 32760,  64, 16, 7};
        vecs[1] = '{4'b0000, 1, 1, 160, -32768, 64, 16, 7};
        vecs[2] = '{4'b0010, 2, 1, 160, 0,      64, 16, 7};
        vecs[3] = '{4'b1110, 4, 1, 160, 16384,  64, 16, 7};
        vecs[4] = '{4'b0001, 1, 2, 160, 32760,  64, 32, 7};

        repeat (3) @(negedge clk);
        check("reset_out", longint'(out), 0);
        check("reset_valid", longint'(outValid), 0);
        rst = 1'b0;

        // Table-driven steady patterns.
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b0);
            tbl_active = 1'b1;
            tbl_exp    = vecs[v].exp_out;
            for (int k = 0; k < vecs[v].n_en; k++) begin
                step(1'b1, vecs[v].pat[vecs[v].plen - 1 - (k % vecs[v].plen)]);
                if (vecs[v].en_div == 2) step(1'b0, 1'($urandom_range(0, 1)));
            end
            tbl_active = 1'b0;
            check($sformatf("v%0d_first_en", v), first_en, vecs[v].exp_first);
            check($sformatf("v%0d_min_spacing", v), min_sp, vecs[v].exp_spacing);
            check($sformatf("v%0d_max_spacing", v), max_sp, vecs[v].exp_spacing);
            check($sformatf("v%0d_pulses", v), npulse, vecs[v].exp_pulses);
            check($sformatf("v%0d_queue_empty", v), exp_q.size(), 0);
        end

        // Reset landing on the outValid cycle: the pulse and sample must drop at once.
        do_reset(1'b0);
        for (int k = 0; k < 64; k++) step(1'b1, 1'b1);
        check("pre_rst_valid", longint'(outValid), 1);
        check("pre_rst_out", longint'(out), 32760);
        do_reset(1'b1);

        // Reset mid-window at en sample 40, then a fresh warm-up.
        for (int k = 0; k < 40; k++) step(1'b1, 1'b1);
        do_reset(1'b1);
        for (int k = 0; k < 80; k++) step(1'b1, 1'b1);
        check("rst40_first_en", first_en, 64);
        check("rst40_pulses", npulse, 2);
        check("rst40_out", longint'(out), 32760);

        // Random bitstream with random en gaps against the model.
        do_reset(1'b0);
        for (int k = 0; k < 3000; k++) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        check("rand_pulses_seen", longint'(npulse > 20), 1);
        check("rand_queue_empty", exp_q.size(), 0);

        // Long constant-1 run across integrator wrap-around.
        do_reset(1'b0);
        tbl_active = 1'b1;
        tbl_exp    = 32760;
        for (int k = 0; k < (1 << (ORDER * DLOG2 + 2)) + 100; k++) step(1'b1, 1'b1);
        tbl_active = 1'b0;
        check("wrap_pulses", npulse, ((1 << (ORDER * DLOG2 + 2)) + 100) / R - ORDER);
        check("wrap_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_cic_decimator.md
# sd_cic_decimator

Sigma-delta demodulator: converts a 1-bit sigma-delta bitstream, such as the output of the codebase's sigma-delta DAC/averaging blocks, back into signed multi-bit PCM samples. It uses a cascaded integrator-comb (sinc^N) decimation filter with a power-of-two rate. It sits on the receive side of a sigma-delta link, and benches use it to check modulator outputs numerically.

## Interface
- ORDER, default 3: number of integrator and comb stages (N); legal range 1..4.
- DEC_RATE_LOG2, default 4: log2 of the decimation ratio R; R = 16 by default; legal range 1..8.
- OUT_WIDTH, default 16: width of the signed PCM output.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  sample strobe; `in` is consumed only on cycles with en=1.
- in  in  1  sigma-delta bit; 1 maps to +1, 0 maps to −1.
- out  out  OUT_WIDTH  signed decimated sample; holds its value between strobes.
- outValid  out  1  one-cycle pulse marking a new `out`.

## Operation
- Widths:
  - ACC = ORDER·DEC_RATE_LOG2 + 2 bits, signed, for all integrators, comb delays and differences.
  - W = ORDER·DEC_RATE_LOG2 + 1.
- All integrator and comb arithmetic is modulo 2^ACC. Wrap-around is intended and must not be saturated.
- Integrators, on each en=1 cycle:
  - I1 += (in ? +1 : −1).
  - Ik += I(k−1) for k = 2..ORDER, all updated in the same cycle.
- Phase counter (DEC_RATE_LOG2 bits) increments on each en=1 cycle. The cycle on which it wraps from R−1 to 0 is the decimation event.
- Decimation event:
  - The post-update value of I_ORDER feeds the comb chain.
  - Each comb computes Ck = x − delay_k, then sets delay_k ← x.
  - All combs are evaluated combinationally within the event cycle.
- The comb result c lies in [−2^(W−1), +2^(W−1)]. It is clamped to [−2^(W−1), 2^(W−1)−1] to form a W-bit signed value.
- Output scaling:
  - If OUT_WIDTH ≥ W, the clamped value is left-shifted by OUT_WIDTH−W.
  - Otherwise it is arithmetic right-shifted by W−OUT_WIDTH (truncation toward −∞).
- Warm-up counter: the first ORDER decimation events after reset update the comb delays but do not assert outValid or update `out`. From event ORDER+1 onward, every event produces an output.
- en=0 freezes all state: integrators, phase, delays and warm-up counter.

## Timing
- Reset values: all integrators, comb delays, phase and warm-up counter are 0; out = 0; outValid = 0.
- Latency: `out` and outValid are registered. outValid is high on the clock cycle after the en cycle that completes sample R of a window.
- outValid is high for exactly one cycle per emitted sample. The minimum spacing between pulses is R clocks (with en held high).
- rst asserted at any point, including mid-window or during the outValid cycle, immediately clears all state. Warm-up restarts, and partial-window data is discarded.
- No back-pressure: the consumer must take `out` on the outValid cycle, or before the next pulse.

## Structure
- Shared sigma-delta package:
  - the ACC/W width function of ORDER and DEC_RATE_LOG2;
  - the clamp/scale function;
  - the bit-to-±1 mapping constant.
- One sub-module, sd_cic_comb_stage: a single registered-delay differentiator, parameterised by ACC, with clk/rst/load inputs. The top level instantiates ORDER copies in a generate loop. Integrators stay inline.

## Test plan
- Defaults, rst released, en=1, in=1 constant: first outValid one clock after the 64th en cycle; every pulse gives out = 32760 (clamped 4095 << 3). Pulses are spaced 16 clocks apart.
- in=0 constant: every emitted out = −32768.
- Alternating 1,0: every emitted out = 0. Pattern 1,1,1,0 repeating: out = 16384.
- en toggled every other clock with in=1: identical values to the first scenario, pulses spaced 32 clocks apart. No state changes on en=0 cycles.
- rst asserted for 1 cycle at en sample 40 of a constant-1 run: out = 0 and outValid = 0 immediately. The next outValid arrives 64 en cycles after release.
- Long run, 2^ACC + 100 en cycles, of in=1: outputs remain 32760 across integrator wrap-around. Random bitstream compared against a behavioural sinc^3 model, bit-exact.
